scr1_ahb_imem_slave: RTL and testbench
======================================

# scr1_ahb_imem_slave

AHB-Lite read-only instruction memory slave that terminates the instruction fetch bus driven by the core's IMEM AHB bridge. It accepts single 32-bit NONSEQ/SEQ reads, returns data from an internal word array after a configurable number of wait states, and signals the two-cycle AHB ERROR response for illegal accesses. A side-band preload port fills the array from a boot loader or the testbench.

## Interface
- MEM_SIZE_BYTES, 65536: array size; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000: first decoded byte address; aligned to MEM_SIZE_BYTES.
- WAIT_STATES, 0: data-phase wait cycles per transfer, 0..15.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  SCR1_AHB_WIDTH  byte address, address phase.
- htrans  in  2  transfer type.
- hsize  in  3  transfer size.
- hburst, hprot, hmastlock  in  3/4/1  accepted and ignored.
- hready  out  1  transfer done / slave ready; point-to-point, also used as the slave's own hready input.
- hrdata  out  SCR1_AHB_WIDTH  read data.
- hresp  out  1  SCR1_HRESP_OKAY / SCR1_HRESP_ERROR.
- init_we  in  1  preload write strobe.
- init_addr  in  $clog2(MEM_SIZE_BYTES/4)  preload word index.
- init_wdata  in  32  preload data.

## Operation
- Accept condition: hready & hsel & htrans[1], where htrans[1] selects NONSEQ or SEQ. SEQ is handled identically to NONSEQ.
- IDLE and BUSY transfers, or hsel=0 with hready=1, produce no state change.
- An accepted transfer is an error if any of these holds: hsize != SCR1_HSIZE_32B; haddr[1:0] != 0; haddr outside [BASE_ADDR, BASE_ADDR+MEM_SIZE_BYTES).
- FSM states:
  - IDLE: hready=1, hresp=OKAY. On a legal accept, go to DATA and load the wait counter with WAIT_STATES. On an illegal accept, go to ERR1.
  - DATA: hready = (cnt==0). While cnt!=0, decrement. When cnt==0 the transfer completes; a new accept in the same cycle loads DATA or ERR1, otherwise go to IDLE.
  - ERR1: hready=0, hresp=ERROR. Always go to ERR2.
  - ERR2: hready=1, hresp=ERROR. A new accept in this cycle is legal and leads to DATA or ERR1; otherwise go to IDLE.
- Read: on a legal accept, capture rdata_r <= mem[(haddr-BASE_ADDR)>>2]. Hold rdata_r until the next legal accept.
- hrdata = rdata_r in all states. Its value is defined only when DATA and hready=1.
- Preload: on init_we at posedge clk, mem[init_addr] <= init_wdata. This is independent of the FSM. If a read of the same word is captured in the same cycle, it returns the old contents.
- Reset (asserted, including mid-transfer): FSM=IDLE, cnt=0, rdata_r=0, so hready=1, hresp=OKAY, hrdata=0. The array is not reset and its contents persist. The aborted transfer is never completed.

## Timing
- Accept at edge T. With WAIT_STATES=N, the data phase occupies cycles T+1..T+1+N, and hready=1 with valid hrdata in cycle T+1+N.
- N=0: back-to-back pipelined reads complete one word per cycle with no bubbles.
- Error: ERR1 in cycle T+1 and ERR2 in cycle T+2, regardless of WAIT_STATES.
- Outputs are registered-state decodes; there is no combinational path from AHB inputs to hready or hresp.

## Structure
- AHB constants (SCR1_AHB_WIDTH, SCR1_HTRANS_*, SCR1_HRESP_*, SCR1_HSIZE_32B) come from the shared scr1_ahb.svh.
- The FSM enum and the wait counter are local to the block.
- Sub-module scr1_imem_sp_array: word array with one synchronous read port (en, idx, rdata) and one write port (we, idx, wdata), with no reset. The slave instantiates one.
- Simulation assertions: hsel/htrans never X after reset; WAIT_STATES <= 15; MEM_SIZE_BYTES is a power of two.

## Test plan
- Preload words 0..3 with 32'h1111_1111..32'h4444_4444; WAIT_STATES=0; four back-to-back NONSEQ reads at 0x0, 0x4, 0x8, 0xC -> hready stays 1 and hrdata is 11111111/22222222/33333333/44444444 in consecutive cycles, all OKAY.
- WAIT_STATES=3; single read at 0x8 -> hready low for 3 data-phase cycles, then high with hrdata=33333333 and OKAY.
- Read at 0x2, read with hsize=3'b001, and read at BASE+MEM_SIZE_BYTES -> each gets ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1), followed by IDLE.
- ERR2 with a NONSEQ at 0x4 presented -> transfer accepted; next cycle DATA with hrdata=22222222, OKAY.
- Assert rst_n low during the 2nd wait cycle of a WAIT_STATES=3 read -> immediately hready=1, hresp=0, hrdata=0; after release, a read at 0x0 returns 11111111 (array retained).
- Same-cycle init_we to word 1 with 32'hDEAD_BEEF and accept of a read at 0x4 -> returns 22222222; the following read at 0x4 returns DEADBEEF.

Source files
------------

// File: rtl/scr1_ahb_imem_slave_pkg.sv
// Shared AHB-Lite encodings and local types for the instruction memory slave.
package scr1_ahb_imem_slave_pkg;

  // AHB-Lite bus encodings used by the IMEM fetch path
  localparam int unsigned   SCR1_AHB_WIDTH     = 32;
  localparam logic [1:0]    SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]    SCR1_HTRANS_SEQ    = 2'b11;
  localparam logic          SCR1_HRESP_OKAY    = 1'b0;
  localparam logic          SCR1_HRESP_ERROR   = 1'b1;
  localparam logic [2:0]    SCR1_HSIZE_32B     = 3'b010;

  // Wait-state counter width; covers WAIT_STATES up to 15
  localparam int unsigned   IMEM_CNT_W         = 4;

  // Slave protocol state: idle, data phase, and the two ERROR response cycles
  typedef enum logic [1:0] {
    IMEM_IDLE = 2'b00,
    IMEM_DATA = 2'b01,
    IMEM_ERR1 = 2'b10,
    IMEM_ERR2 = 2'b11
  } imem_state_e;

  // Width of a word index into an array of the given byte size (never below 1 bit)
  function automatic int unsigned imem_idx_width(input int unsigned mem_size_bytes);
    return (mem_size_bytes >= 8) ? $clog2(mem_size_bytes / 4) : 1;
  endfunction

  // True when v is a non-zero power of two
  function automatic logic imem_is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/scr1_ahb_imem_slave_if.sv
// AHB-Lite instruction fetch bus between the IMEM bridge (master) and the memory slave.
interface scr1_ahb_imem_slave_if;
  import scr1_ahb_imem_slave_pkg::*;

  logic                      hsel;
  logic [SCR1_AHB_WIDTH-1:0] haddr;
  logic [1:0]                htrans;
  logic [2:0]                hsize;
  logic [2:0]                hburst;
  logic [3:0]                hprot;
  logic                      hmastlock;
  logic                      hready;
  logic [SCR1_AHB_WIDTH-1:0] hrdata;
  logic                      hresp;

  modport master (
    output hsel, haddr, htrans, hsize, hburst, hprot, hmastlock,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hburst, hprot, hmastlock,
    output hready, hrdata, hresp
  );

endinterface

// File: rtl/scr1_imem_sp_array.sv
// Word array with one synchronous read port and one write port; contents are never reset.
module scr1_imem_sp_array #(
  parameter int unsigned WORDS = 16384,
  parameter int unsigned IDX_W = 14
) (
  input  logic             clk,
  input  logic             en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wdata
);

  logic [31:0] mem [WORDS];

  // Write and read share the edge; a read of the word being written sees the old contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wdata;
    end
    if (en) begin
      rdata <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/scr1_ahb_imem_slave.sv
// AHB-Lite read-only instruction memory slave with configurable wait states,
// two-cycle ERROR response for illegal accesses and a side-band preload port.
module scr1_ahb_imem_slave
  import scr1_ahb_imem_slave_pkg::*;
#(
  parameter int unsigned               MEM_SIZE_BYTES = 65536,
  parameter logic [SCR1_AHB_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned               WAIT_STATES    = 0,
  localparam int unsigned              IDX_W          = imem_idx_width(MEM_SIZE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scr1_ahb_imem_slave_if.slave  ahb,
  input  logic                  init_we,
  input  logic [IDX_W-1:0]      init_addr,
  input  logic [31:0]           init_wdata
);

  localparam int unsigned               WORDS      = (MEM_SIZE_BYTES >= 8) ? (MEM_SIZE_BYTES / 4) : 1;
  localparam logic [SCR1_AHB_WIDTH-1:0] MEM_SIZE_L = SCR1_AHB_WIDTH'(MEM_SIZE_BYTES);
  localparam logic [IMEM_CNT_W-1:0]     WS_L       = IMEM_CNT_W'(WAIT_STATES);

  imem_state_e               state;
  imem_state_e               state_nxt;
  logic [IMEM_CNT_W-1:0]     cnt;
  logic [IMEM_CNT_W-1:0]     cnt_nxt;
  logic                      slv_ready;
  logic                      slv_resp;
  logic                      accept;
  logic                      legal;
  logic                      rd_en;
  logic                      rdata_vld;
  logic [SCR1_AHB_WIDTH-1:0] offset;
  logic [IDX_W-1:0]          rd_idx;
  logic [31:0]               arr_rdata;
  logic                      unused_sideband;

  // Burst, protection and lock attributes carry no meaning for this memory
  assign unused_sideband = ^{ahb.hburst, ahb.hprot, ahb.hmastlock};

  // Address decode: wrap-around subtraction makes addresses below BASE_ADDR fall out of range too
  assign offset = ahb.haddr - BASE_ADDR;
  assign legal  = (ahb.hsize == SCR1_HSIZE_32B)
                & (ahb.haddr[1:0] == 2'b00)
                & (offset < MEM_SIZE_L);
  assign rd_idx = offset[IDX_W+1:2];

  // Output decode from the registered state, then accept and next-state selection
  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = SCR1_HRESP_OKAY;
    accept    = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_en     = 1'b0;

    case (state)
      IMEM_DATA: slv_ready = (cnt == '0);
      IMEM_ERR1: begin
        slv_ready = 1'b0;
        slv_resp  = SCR1_HRESP_ERROR;
      end
      IMEM_ERR2: slv_resp = SCR1_HRESP_ERROR;
      default: ;
    endcase

    accept = slv_ready & ahb.hsel
           & ((ahb.htrans == SCR1_HTRANS_NONSEQ) | (ahb.htrans == SCR1_HTRANS_SEQ));

    if (state == IMEM_ERR1) begin
      state_nxt = IMEM_ERR2;
    end else if ((state == IMEM_DATA) && (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end else if (accept) begin
      if (legal) begin
        state_nxt = IMEM_DATA;
        cnt_nxt   = WS_L;
        rd_en     = 1'b1;
      end else begin
        state_nxt = IMEM_ERR1;
      end
    end else begin
      state_nxt = IMEM_IDLE;
    end
  end

  // State and wait counter registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IMEM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The array's read register has no reset, so this flag forces hrdata to zero until the first legal read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_vld <= 1'b0;
    end else if (rd_en) begin
      rdata_vld <= 1'b1;
    end
  end

  scr1_imem_sp_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk    (clk),
    .en     (rd_en),
    .rd_idx (rd_idx),
    .rdata  (arr_rdata),
    .we     (init_we),
    .wr_idx (init_addr),
    .wdata  (init_wdata)
  );

  assign ahb.hready = slv_ready;
  assign ahb.hresp  = slv_resp;
  assign ahb.hrdata = rdata_vld ? arr_rdata : '0;

  // Simulation sanity checks on the bus and the parameter set
  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
                                 !$isunknown({ahb.hsel, ahb.htrans}));
  a_wait_range: assert property (@(posedge clk) WAIT_STATES <= 15);
  a_size_pow2:  assert property (@(posedge clk)
                                 imem_is_pow2(MEM_SIZE_BYTES) && (MEM_SIZE_BYTES >= 4));
  a_base_align: assert property (@(posedge clk)
                                 (BASE_ADDR & (MEM_SIZE_L - 1'b1)) == '0);

endmodule

// File: tb/tb_scr1_ahb_imem_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) driven through AHB tasks,
// expected responses queued at accept time and compared when each data phase ends.
`timescale 1ns/1ps
module tb_scr1_ahb_imem_slave;
  import scr1_ahb_imem_slave_pkg::*;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] SZ_WORD   = 3'b010;
  localparam int         WS0       = 0;
  localparam int         WS1       = 3;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_we0, init_we1;
  logic [13:0] init_addr0, init_addr1;
  logic [31:0] init_wdata0, init_wdata1;

  int          totalChecks = 0;
  int          badChecks = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] model0[16];
  logic [31:0] model1[16];
  bit          inPhase[2];
  int          waitCnt[2];

  always #5 clk = ~clk;

  scr1_ahb_imem_slave_if bus0();
  scr1_ahb_imem_slave_if bus1();

  scr1_ahb_imem_slave #(
    .MEM_SIZE_BYTES (65536),
    .BASE_ADDR      (32'h0000_0000),
    .WAIT_STATES    (WS0)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ahb        (bus0),
    .init_we    (init_we0),
    .init_addr  (init_addr0),
    .init_wdata (init_wdata0)
  );

  scr1_ahb_imem_slave #(
    .MEM_SIZE_BYTES (65536),
    .BASE_ADDR      (32'h0000_0000),
    .WAIT_STATES    (WS1)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ahb        (bus1),
    .init_we    (init_we1),
    .init_addr  (init_addr1),
    .init_wdata (init_wdata1)
  );

  // Count one comparison and report it when observed and required differ
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive the address-phase signals of one slave
  task automatic driveBus(input int d, input logic sel, input logic [1:0] trans,
                          input logic [31:0] addr, input logic [2:0] size);
    if (d == 0) begin
      bus0.hsel = sel; bus0.htrans = trans; bus0.haddr = addr; bus0.hsize = size;
    end else begin
      bus1.hsel = sel; bus1.htrans = trans; bus1.haddr = addr; bus1.hsize = size;
    end
  endtask

  task automatic idleBus(input int d);
    driveBus(d, 1'b0, HT_IDLE, 32'h0, SZ_WORD);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write one word into both arrays and the bench's reference copies
  task automatic preload(input int idx, input logic [31:0] data);
    init_we0 = 1'b1; init_addr0 = 14'(idx); init_wdata0 = data;
    init_we1 = 1'b1; init_addr1 = 14'(idx); init_wdata1 = data;
    @(posedge clk);
    #1;
    init_we0 = 1'b0;
    init_we1 = 1'b0;
    model0[idx] = data;
    model1[idx] = data;
  endtask

  // Present one transfer, hold it until the slave is ready, queue the expected response
  task automatic applyStimulus(input int d, input logic [1:0] trans,
                               input logic [31:0] addr, input logic [2:0] size);
    exp_t e;
    int   guard;
    bit   taken;
    driveBus(d, 1'b1, trans, addr, size);
    guard = 0;
    taken = 1'b0;
    while (!taken && guard < 40) begin
      @(negedge clk);
      guard++;
      taken = (d == 0) ? (bus0.hready === 1'b1) : (bus1.hready === 1'b1);
    end
    if (!taken) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.err   = (size != SZ_WORD) || (addr[1:0] != 2'b00) || (addr >= 32'h0001_0000);
      e.data  = e.err ? 32'h0 : ((d == 0) ? model0[addr[5:2]] : model1[addr[5:2]]);
      e.waits = e.err ? 1 : ((d == 0) ? WS0 : WS1);
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Per-cycle observer: completes queued transfers and checks idle cycles
  task automatic monitorStep(input int d, input logic sel, input logic [1:0] trans,
                             input logic rdy, input logic rsp, input logic [31:0] rd);
    exp_t  e;
    string p;
    int    depth;
    p = (d == 0) ? "d0" : "d1";
    depth = (d == 0) ? sb0.size() : sb1.size();
    if (inPhase[d]) begin
      if (depth == 0) begin
        checkOutput({p, "_sb_underflow"}, 32'd1, 32'd0);
        inPhase[d] = 1'b0;
      end else begin
        e = (d == 0) ? sb0[0] : sb1[0];
        if (rdy === 1'b1) begin
          checkOutput({p, "_resp"}, {31'd0, rsp}, {31'd0, e.err});
          if (!e.err) checkOutput({p, "_rdata"}, rd, e.data);
          checkOutput({p, "_waits"}, waitCnt[d], e.waits);
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          inPhase[d] = 1'b0;
        end else begin
          waitCnt[d]++;
          checkOutput({p, "_wait_resp"}, {31'd0, rsp}, {31'd0, e.err});
          if (waitCnt[d] > 20) begin
            checkOutput({p, "_wait_timeout"}, waitCnt[d], e.waits);
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            inPhase[d] = 1'b0;
          end
        end
      end
    end else begin
      checkOutput({p, "_idle_rdy"}, {31'd0, rdy}, 32'd1);
      checkOutput({p, "_idle_resp"}, {31'd0, rsp}, 32'd0);
    end
    if (rdy === 1'b1 && sel === 1'b1 && trans[1] === 1'b1) begin
      inPhase[d] = 1'b1;
      waitCnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      inPhase[0] = 1'b0;
      sb0.delete();
    end else begin
      monitorStep(0, bus0.hsel, bus0.htrans, bus0.hready, bus0.hresp, bus0.hrdata);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      inPhase[1] = 1'b0;
      sb1.delete();
    end else begin
      monitorStep(1, bus1.hsel, bus1.htrans, bus1.hready, bus1.hresp, bus1.hrdata);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      model0[i] = 32'h0;
      model1[i] = 32'h0;
    end
    init_we0 = 1'b0; init_addr0 = '0; init_wdata0 = '0;
    init_we1 = 1'b0; init_addr1 = '0; init_wdata1 = '0;
    bus0.hburst = 3'b000; bus0.hprot = 4'b0011; bus0.hmastlock = 1'b0;
    bus1.hburst = 3'b000; bus1.hprot = 4'b0011; bus1.hmastlock = 1'b0;
    idleBus(0);
    idleBus(1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_d0_rdy",   {31'd0, bus0.hready}, 32'd1);
    checkOutput("rst_d0_resp",  {31'd0, bus0.hresp},  32'd0);
    checkOutput("rst_d0_rdata", bus0.hrdata,          32'd0);
    checkOutput("rst_d1_rdy",   {31'd0, bus1.hready}, 32'd1);
    checkOutput("rst_d1_resp",  {31'd0, bus1.hresp},  32'd0);
    checkOutput("rst_d1_rdata", bus1.hrdata,          32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] preloading words 0..3");
    for (int i = 0; i < 4; i++) preload(i, {8{4'(i + 1)}});

    $display("[TB] back-to-back reads, no wait states");
    applyStimulus(0, HT_NONSEQ, 32'h0, SZ_WORD);
    applyStimulus(0, HT_NONSEQ, 32'h4, SZ_WORD);
    applyStimulus(0, HT_NONSEQ, 32'h8, SZ_WORD);
    applyStimulus(0, HT_NONSEQ, 32'hC, SZ_WORD);
    idleBus(0);
    waitCycles(3);

    $display("[TB] single read with three wait states");
    applyStimulus(1, HT_NONSEQ, 32'h8, SZ_WORD);
    idleBus(1);
    waitCycles(6);

    $display("[TB] SEQ read and ignored transfers");
    applyStimulus(0, HT_SEQ, 32'hC, SZ_WORD);
    idleBus(0);
    waitCycles(2);
    driveBus(0, 1'b0, HT_NONSEQ, 32'h0, SZ_WORD);
    waitCycles(2);
    checkOutput("d0_hold_rdata", bus0.hrdata, model0[3]);
    idleBus(0);
    driveBus(1, 1'b1, HT_BUSY, 32'h4, SZ_WORD);
    waitCycles(2);
    driveBus(1, 1'b1, HT_IDLE, 32'h4, SZ_WORD);
    waitCycles(2);
    driveBus(1, 1'b0, HT_NONSEQ, 32'h4, SZ_WORD);
    waitCycles(2);
    idleBus(1);
    waitCycles(1);

    $display("[TB] illegal accesses");
    applyStimulus(0, HT_NONSEQ, 32'h2, SZ_WORD);
    idleBus(0);
    waitCycles(3);
    applyStimulus(0, HT_NONSEQ, 32'h4, 3'b001);
    idleBus(0);
    waitCycles(3);
    applyStimulus(0, HT_NONSEQ, 32'h0001_0000, SZ_WORD);
    idleBus(0);
    waitCycles(3);
    applyStimulus(1, HT_NONSEQ, 32'h0001_0000, SZ_WORD);
    idleBus(1);
    waitCycles(3);

    $display("[TB] accept during the second error cycle");
    applyStimulus(0, HT_NONSEQ, 32'h2, SZ_WORD);
    applyStimulus(0, HT_NONSEQ, 32'h4, SZ_WORD);
    idleBus(0);
    waitCycles(3);

    $display("[TB] reset in the middle of a wait-state read");
    applyStimulus(1, HT_NONSEQ, 32'h0, SZ_WORD);
    idleBus(1);
    @(posedge clk);
    #1;
    checkOutput("d1_pre_rst_rdy", {31'd0, bus1.hready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("d1_mid_rst_rdy",   {31'd0, bus1.hready}, 32'd1);
    checkOutput("d1_mid_rst_resp",  {31'd0, bus1.hresp},  32'd0);
    checkOutput("d1_mid_rst_rdata", bus1.hrdata,          32'd0);
    checkOutput("d0_mid_rst_rdata", bus0.hrdata,          32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(1);
    applyStimulus(1, HT_NONSEQ, 32'h0, SZ_WORD);
    idleBus(1);
    waitCycles(6);

    $display("[TB] preload write colliding with a read");
    init_we0 = 1'b1; init_addr0 = 14'd1; init_wdata0 = 32'hDEAD_BEEF;
    applyStimulus(0, HT_NONSEQ, 32'h4, SZ_WORD);
    init_we0 = 1'b0;
    model0[1] = 32'hDEAD_BEEF;
    applyStimulus(0, HT_NONSEQ, 32'h4, SZ_WORD);
    idleBus(0);
    waitCycles(3);

    checkOutput("d0_sb_empty", sb0.size(), 32'd0);
    checkOutput("d1_sb_empty", sb1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
